timing_sequencer: RTL and testbench
===================================

TIMING_SEQUENCER -- requirements
Module: timing_sequencer

Interface
REQ-001 Parameter DIV, default 4: SIM_CLK cycles per phase slot (W/X/Y/Z); legal range 2..16.
REQ-002 Parameter BIT_TIMES, default 14: bit times per word; legal range 2..16.
REQ-003 SIM_CLK  in  1  the single clock, rising-edge active.
REQ-004 SIM_RST  in  1  asynchronous, active-high reset.
REQ-005 RUN_REQ  in  1  level request for continuous running.
REQ-006 HALT_REQ  in  1  level request to stop at the next word boundary.
REQ-007 STEP_REQ  in  1  pulse request to run exactly one word, then halt.
REQ-008 CGPP, CGPPN, CGQP, CGQPN, CGRP, CGRPN  out  1 each  phase-code lines for the W/X/Y/Z clock drivers, each with its true complement.
REQ-009 BOP  out  1  bit-oscillator-permit; high only while phases advance.
REQ-010 PHASE  out  2  current phase: 0=W, 1=X, 2=Y, 3=Z.
REQ-011 BT  out  4  current bit-time number, 0..BIT_TIMES-1.
REQ-012 WORD_END  out  1  one-cycle pulse on the last SIM_CLK cycle of Z in bit time BIT_TIMES-1 while advancing.
REQ-013 HALTED  out  1  high while the sequencer is frozen.

Function
REQ-014 Phase code (P,Q,R) SHALL be W=(1,0,1), X=(0,1,1), Y=(1,1,0), Z=(0,0,0); each xN output SHALL be the exact inverse of its xP output in every cycle.
REQ-015 Every phase-code output SHALL be driven directly from a flop, with no combinational path from any input.
REQ-016 A divider count 0..DIV-1 SHALL increment each cycle while advancing. At DIV-1 it SHALL wrap to 0 and PHASE SHALL advance W->X->Y->Z->W.
REQ-017 BT SHALL increment when PHASE advances Z->W, and SHALL wrap BIT_TIMES-1 -> 0.
REQ-018 The FSM SHALL have four states:
- HALT: frozen; BOP=0; HALTED=1.
- RUN: advancing; BOP=1.
- STEP: advancing; BOP=1.
- DRAIN: advancing; BOP=1; halt pending.
REQ-019 Transitions from HALT, in priority order:
- RUN_REQ=1 -> RUN.
- Else STEP_REQ=1 -> STEP.
- Else stay in HALT.
REQ-020 Transitions from RUN:
- HALT_REQ=1 or RUN_REQ=0 -> DRAIN.
- STEP_REQ is ignored.
REQ-021 Transitions from STEP and DRAIN:
- Go to HALT on the cycle after WORD_END.
- All requests are ignored until then.
REQ-022 Special cases: if the exit condition arises in RUN on the WORD_END cycle itself, the FSM SHALL go directly to HALT. HALT_REQ and RUN_REQ both high SHALL resolve as halt.
REQ-023 In HALT, the divider, PHASE and BT SHALL hold at 0/W/0 and the phase code SHALL hold W. Halting therefore always occurs on a word boundary, with the next advance starting at W, BT 0, divider 0.
REQ-024 The first advancing cycle SHALL be the cycle after the request is sampled in HALT (one-cycle latency); BOP SHALL rise in that same cycle.
REQ-025 HALTED SHALL fall in the same cycle BOP rises, and SHALL rise in the same cycle BOP falls.

Reset
REQ-026 While SIM_RST=1, outputs SHALL immediately be:
- state HALT, divider 0, PHASE=0, BT=0;
- CGPP=1, CGQP=0, CGRP=1, with complements inverted;
- BOP=0, WORD_END=0, HALTED=1.
REQ-027 Reset asserted mid-word SHALL abandon the word with no WORD_END pulse.
REQ-028 After reset release, the block SHALL stay in HALT until a request is sampled; a request held high during reset SHALL be honoured on the first clock after release.

Structure
REQ-029 A shared package SHALL hold:
- the FSM state enumeration;
- the phase enumeration (W/X/Y/Z);
- the 3-bit phase-code constants for W, X, Y and Z.
REQ-030 One sub-module, phase_divider, SHALL hold the divider count and PHASE/BT counters. It SHALL have an advance-enable input and a word-end output; the FSM and output flops SHALL stay in timing_sequencer.

Verification
REQ-031 Reset, then RUN_REQ=1 held (DIV=4, BIT_TIMES=14):
- BOP rises 1 cycle after release.
- Phase code cycles W,X,Y,Z at 4 cycles per phase.
- WORD_END pulses every 224 cycles.
REQ-032 HALT_REQ pulse at BT=5, phase X while running:
- Advancing continues to the end of BT 13 Z.
- HALTED rises the cycle after WORD_END.
- Outputs freeze at W, BT 0.
REQ-033 STEP_REQ single pulse in HALT:
- Exactly 224 advancing cycles and one WORD_END pulse occur.
- Then HALT, with BOP=0.
REQ-034 STEP_REQ and RUN_REQ asserted together in HALT: the FSM enters RUN, and no halt occurs after the first word while RUN_REQ stays high.
REQ-035 SIM_RST asserted at BT=7 phase Y:
- Outputs go to reset values without waiting for a clock edge.
- No WORD_END pulse occurs.
- CGxP and CGxN remain complementary throughout.
REQ-036 Parameter sweep DIV=2, BIT_TIMES=2: the WORD_END period is 16 cycles and BT alternates 0,1.

Source files
------------

// File: rtl/timing_sequencer_pkg.sv
// Shared types and phase-code constants for the W/X/Y/Z timing sequencer.
package timing_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PH_W = 2'd0,
        PH_X = 2'd1,
        PH_Y = 2'd2,
        PH_Z = 2'd3
    } phase_e;

    // Phase code bits are ordered {P, Q, R}.
    localparam logic [2:0] CODE_W = 3'b101;
    localparam logic [2:0] CODE_X = 3'b011;
    localparam logic [2:0] CODE_Y = 3'b110;
    localparam logic [2:0] CODE_Z = 3'b000;

    localparam int CNT_W = 4;

    function automatic logic [2:0] phase_code(input phase_e ph);
        case (ph)
            PH_W:    return CODE_W;
            PH_X:    return CODE_X;
            PH_Y:    return CODE_Y;
            default: return CODE_Z;
        endcase
    endfunction

endpackage

// File: rtl/timing_sequencer_if.sv
// Request inputs and phase/status outputs of the timing sequencer.
interface timing_sequencer_if;
    logic       run_req;
    logic       halt_req;
    logic       step_req;
    logic       cgpp;
    logic       cgppn;
    logic       cgqp;
    logic       cgqpn;
    logic       cgrp;
    logic       cgrpn;
    logic       bop;
    logic [1:0] phase;
    logic [3:0] bt;
    logic       word_end;
    logic       halted;

    modport master (
        output run_req, halt_req, step_req,
        input  cgpp, cgppn, cgqp, cgqpn, cgrp, cgrpn,
        input  bop, phase, bt, word_end, halted
    );

    modport slave (
        input  run_req, halt_req, step_req,
        output cgpp, cgppn, cgqp, cgqpn, cgrp, cgrpn,
        output bop, phase, bt, word_end, halted
    );
endinterface

// File: rtl/timing_sequencer_phase_divider.sv
// Divider, phase and bit-time counters; they advance only while i_adv is high
// and return to 0/W/0 whenever advancing stops.
module phase_divider
    import timing_sequencer_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int BIT_TIMES = 14
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_adv,
    output phase_e           o_phase,
    output phase_e           o_phase_next,
    output logic [CNT_W-1:0] o_bt,
    output logic             o_word_end
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BT_LAST  = CNT_W'(BIT_TIMES - 1);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] w_div_next;
    logic [CNT_W-1:0] r_bt;
    logic [CNT_W-1:0] w_bt_next;
    phase_e           r_phase;
    phase_e           w_phase_next;
    logic             w_div_wrap;

    assign w_div_wrap = (r_div == DIV_LAST);

    always_comb begin
        w_div_next   = r_div;
        w_phase_next = r_phase;
        w_bt_next    = r_bt;
        if (!i_adv) begin
            w_div_next   = '0;
            w_phase_next = PH_W;
            w_bt_next    = '0;
        end else if (w_div_wrap) begin
            w_div_next   = '0;
            w_phase_next = phase_e'(r_phase + 2'd1);
            if (r_phase == PH_Z) begin
                w_bt_next = (r_bt == BT_LAST) ? '0 : r_bt + 1'b1;
            end
        end else begin
            w_div_next = r_div + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div   <= '0;
            r_phase <= PH_W;
            r_bt    <= '0;
        end else begin
            r_div   <= w_div_next;
            r_phase <= w_phase_next;
            r_bt    <= w_bt_next;
        end
    end

    assign o_phase      = r_phase;
    assign o_phase_next = w_phase_next;
    assign o_bt         = r_bt;
    assign o_word_end   = i_adv && w_div_wrap && (r_phase == PH_Z) && (r_bt == BT_LAST);

endmodule

// File: rtl/timing_sequencer.sv
// Run/step/halt control for the W/X/Y/Z phase sequencer; halting is only ever
// taken at a word boundary so the next start is always W, BT 0.
module timing_sequencer
    import timing_sequencer_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int BIT_TIMES = 14
) (
    input  logic              i_sim_clk,
    input  logic              i_sim_rst,
    timing_sequencer_if.slave bus
);

    state_e           r_state;
    logic             r_bop;
    logic             r_halted;
    logic [2:0]       r_code_p;
    logic [2:0]       r_code_n;
    phase_e           w_phase;
    phase_e           w_phase_next;
    logic [CNT_W-1:0] w_bt;
    logic             w_word_end;
    logic             w_exit;

    phase_divider #(
        .DIV       (DIV),
        .BIT_TIMES (BIT_TIMES)
    ) u_phase_divider (
        .i_clk        (i_sim_clk),
        .i_rst        (i_sim_rst),
        .i_adv        (r_bop),
        .o_phase      (w_phase),
        .o_phase_next (w_phase_next),
        .o_bt         (w_bt),
        .o_word_end   (w_word_end)
    );

    // Halt wins when both HALT_REQ and RUN_REQ are high.
    assign w_exit = bus.halt_req || !bus.run_req;

    always_ff @(posedge i_sim_clk or posedge i_sim_rst) begin
        if (i_sim_rst) begin
            r_state  <= ST_HALT;
            r_bop    <= 1'b0;
            r_halted <= 1'b1;
            r_code_p <= CODE_W;
            r_code_n <= ~CODE_W;
        end else begin
            // Complement lines get their own flops so neither rail sits behind an inverter.
            r_code_p <= phase_code(w_phase_next);
            r_code_n <= ~phase_code(w_phase_next);
            case (r_state)
                ST_HALT: begin
                    if (bus.run_req) begin
                        r_state  <= ST_RUN;
                        r_bop    <= 1'b1;
                        r_halted <= 1'b0;
                    end else if (bus.step_req) begin
                        r_state  <= ST_STEP;
                        r_bop    <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_exit && w_word_end) begin
                        r_state  <= ST_HALT;
                        r_bop    <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (w_exit) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_STEP, ST_DRAIN: begin
                    if (w_word_end) begin
                        r_state  <= ST_HALT;
                        r_bop    <= 1'b0;
                        r_halted <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_HALT;
                    r_bop    <= 1'b0;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cgpp     = r_code_p[2];
    assign bus.cgqp     = r_code_p[1];
    assign bus.cgrp     = r_code_p[0];
    assign bus.cgppn    = r_code_n[2];
    assign bus.cgqpn    = r_code_n[1];
    assign bus.cgrpn    = r_code_n[0];
    assign bus.bop      = r_bop;
    assign bus.halted   = r_halted;
    assign bus.phase    = w_phase;
    assign bus.bt       = w_bt;
    assign bus.word_end = w_word_end;

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench: run, halt, step, step+run, async reset mid-word, and a
// DIV=2/BIT_TIMES=2 instance running alongside.
module tb_timing_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    timing_sequencer_if bus1();
    timing_sequencer_if bus2();

    timing_sequencer #(.DIV(4), .BIT_TIMES(14)) u_dut (
        .i_sim_clk (clk),
        .i_sim_rst (rst),
        .bus       (bus1)
    );

    timing_sequencer #(.DIV(2), .BIT_TIMES(2)) u_dut_small (
        .i_sim_clk (clk),
        .i_sim_rst (rst),
        .bus       (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // {bop, word_end, phase, bt, cgpp, cgppn, cgqp, cgqpn, cgrp, cgrpn}
    localparam logic [13:0] FROZEN = {1'b0, 1'b0, 2'd0, 4'd0, 6'b100110};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] code6(input int ph);
        case (ph)
            0:       return 6'b100110;
            1:       return 6'b011010;
            2:       return 6'b101001;
            default: return 6'b010101;
        endcase
    endfunction

    function automatic logic [13:0] obs1();
        return {bus1.bop, bus1.word_end, bus1.phase, bus1.bt,
                bus1.cgpp, bus1.cgppn, bus1.cgqp, bus1.cgqpn, bus1.cgrp, bus1.cgrpn};
    endfunction

    function automatic logic [13:0] obs2();
        return {bus2.bop, bus2.word_end, bus2.phase, bus2.bt,
                bus2.cgpp, bus2.cgppn, bus2.cgqp, bus2.cgqpn, bus2.cgrp, bus2.cgrpn};
    endfunction

    // k = index of the advancing cycle counted from the first cycle after a start.
    function automatic logic [13:0] exp1(input int k);
        int ph;
        int bt;
        ph = (k / 4) % 4;
        bt = (k / 16) % 14;
        return {1'b1, (k % 224) == 223, 2'(ph), 4'(bt), code6(ph)};
    endfunction

    function automatic logic [13:0] exp2(input int k);
        int ph;
        int bt;
        ph = (k / 2) % 4;
        bt = (k / 8) % 2;
        return {1'b1, (k % 16) == 15, 2'(ph), 4'(bt), code6(ph)};
    endfunction

    int we_cnt;
    int bop_cnt;

    initial begin
        bus1.run_req = 1'b0; bus1.halt_req = 1'b0; bus1.step_req = 1'b0;
        bus2.run_req = 1'b0; bus2.halt_req = 1'b0; bus2.step_req = 1'b0;

        // Reset state, and a request held during reset.
        repeat (2) @(negedge clk);
        check("rst_vec", obs1(), FROZEN);
        check("rst_halted", bus1.halted, 1'b1);
        bus1.run_req = 1'b1;
        bus2.run_req = 1'b1;
        @(negedge clk);
        check("rst_req_held", obs1(), FROZEN);
        rst = 1'b0;
        @(negedge clk);

        // Continuous run, then a HALT_REQ pulse at BT 5 phase X of the third word.
        check("start_halted_low", bus1.halted, 1'b0);
        we_cnt = 0;
        for (int k = 0; k < 672; k++) begin
            check("run", obs1(), exp1(k));
            if (k < 448) check("sweep_small", obs2(), exp2(k));
            if (bus1.word_end) we_cnt++;
            if (k == 532) bus1.halt_req = 1'b1;
            if (k == 533) begin
                bus1.halt_req = 1'b0;
                bus1.run_req  = 1'b0;
            end
            @(negedge clk);
        end
        check("run_we_count", we_cnt, 3);
        check("drain_frozen", obs1(), FROZEN);
        check("drain_halted", bus1.halted, 1'b1);
        repeat (5) @(negedge clk);
        check("drain_hold", obs1(), FROZEN);

        // Single-word step.
        bus1.step_req = 1'b1;
        @(negedge clk);
        bus1.step_req = 1'b0;
        bop_cnt = 0;
        we_cnt  = 0;
        for (int i = 0; i < 240; i++) begin
            if (i < 224) check("step", obs1(), exp1(i));
            else         check("step_frozen", obs1(), FROZEN);
            bop_cnt += int'(bus1.bop);
            we_cnt  += int'(bus1.word_end);
            @(negedge clk);
        end
        check("step_bop_cycles", bop_cnt, 224);
        check("step_we_count", we_cnt, 1);
        check("step_halted", bus1.halted, 1'b1);

        // STEP and RUN together: runs past the first word; exit on WORD_END halts at once.
        bus1.step_req = 1'b1;
        bus1.run_req  = 1'b1;
        @(negedge clk);
        bus1.step_req = 1'b0;
        for (int k = 0; k < 448; k++) begin
            check("step_run", obs1(), exp1(k));
            if (k == 447) bus1.run_req = 1'b0;
            @(negedge clk);
        end
        check("we_exit_frozen", obs1(), FROZEN);
        check("we_exit_halted", bus1.halted, 1'b1);

        // Asynchronous reset at BT 7 phase Y.
        bus1.run_req = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 120; k++) begin
            check("pre_rst", obs1(), exp1(k));
            if (k < 120) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check("rst_async", obs1(), FROZEN);
        check("rst_async_halted", bus1.halted, 1'b1);
        bus1.run_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_hold", obs1(), FROZEN);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", obs1(), FROZEN);
        check("post_rst_halted", bus1.halted, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
